st_pkt_arbiter: RTL and testbench

Packet-granular two-input arbiter that shares a single 32-bit Avalon-ST datapath (the stl2sts 32-to-16-bit converter input) between two 32-bit Avalon-ST sources. Grants are round-robin per packet and held from startofpacket to endofpacket, so packets are never interleaved. Sits directly upstream of stl2sts; its source port connects to stl2sts data_in_*.

---
 rtl/st_pkt_arbiter.sv | 115 +++++++++++
 tb/tb_st_pkt_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/st_pkt_arbiter.sv
// Packet-granular round-robin arbiter: two 32-bit Avalon-ST sources onto one datapath.
// Optional macro ST_ARB_CHANNEL_EN adds data_out_channel (granted source tag).
module st_pkt_arbiter #(
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data_in0_data,
  input  logic [1:0]            data_in0_empty,
  input  logic                  data_in0_startofpacket,
  input  logic                  data_in0_endofpacket,
  input  logic                  data_in0_valid,
  output logic                  data_in0_ready,
  input  logic [31:0]           data_in1_data,
  input  logic [1:0]            data_in1_empty,
  input  logic                  data_in1_startofpacket,
  input  logic                  data_in1_endofpacket,
  input  logic                  data_in1_valid,
  output logic                  data_in1_ready,
  output logic [31:0]           data_out_data,
  output logic [1:0]            data_out_empty,
  output logic                  data_out_startofpacket,
  output logic                  data_out_endofpacket,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
`ifdef ST_ARB_CHANNEL_EN
  output logic                  data_out_channel,
`endif
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned SUM_W = DROP_CNT_W + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic             grant;
  logic             rr_ptr;
  logic             req0, req1;
  logic             drop0, drop1;
  logic             xfer_eop;
  logic [SUM_W-1:0] drop_sum;

  assign req0  = data_in0_valid & data_in0_startofpacket;
  assign req1  = data_in1_valid & data_in1_startofpacket;
  assign drop0 = data_in0_valid & ~data_in0_startofpacket;
  assign drop1 = data_in1_valid & ~data_in1_startofpacket;

  assign drop_sum = SUM_W'(drop_count) + SUM_W'(drop0) + SUM_W'(drop1);
  assign xfer_eop = (state == LOCK) & data_out_valid & data_out_ready & data_out_endofpacket;

`ifdef ST_ARB_CHANNEL_EN
  assign data_out_channel = (state == LOCK) & grant;
`endif

  // Output mux and ready steering; reset forces handshakes idle immediately
  always_comb begin
    data_out_data          = '0;
    data_out_empty         = '0;
    data_out_startofpacket = 1'b0;
    data_out_endofpacket   = 1'b0;
    data_out_valid         = 1'b0;
    data_in0_ready         = 1'b0;
    data_in1_ready         = 1'b0;
    if (state == LOCK) begin
      if (grant) begin
        data_out_data          = data_in1_data;
        data_out_empty         = data_in1_empty;
        data_out_startofpacket = data_in1_startofpacket;
        data_out_endofpacket   = data_in1_endofpacket;
        data_out_valid         = data_in1_valid & ~rst;
        data_in1_ready         = data_out_ready & ~rst;
      end else begin
        data_out_data          = data_in0_data;
        data_out_empty         = data_in0_empty;
        data_out_startofpacket = data_in0_startofpacket;
        data_out_endofpacket   = data_in0_endofpacket;
        data_out_valid         = data_in0_valid & ~rst;
        data_in0_ready         = data_out_ready & ~rst;
      end
    end else begin
      // Out-of-packet beats are swallowed; SOP requesters wait for the grant
      data_in0_ready = drop0 & ~rst;
      data_in1_ready = drop1 & ~rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      rr_ptr     <= 1'b0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= (req0 & req1) ? rr_ptr : req1;
            state <= LOCK;
          end
          if (drop_sum[DROP_CNT_W]) drop_count <= '1;
          else                      drop_count <= drop_sum[DROP_CNT_W-1:0];
        end
        LOCK: begin
          if (xfer_eop) begin
            state  <= IDLE;
            rr_ptr <= ~grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_pkt_arbiter.sv
// Directed self-checking bench for st_pkt_arbiter.
module tb_st_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in0_data, in1_data;
  logic [1:0]  in0_empty, in1_empty;
  logic        in0_sop, in0_eop, in0_valid, in0_ready;
  logic        in1_sop, in1_eop, in1_valid, in1_ready;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic        out_sop, out_eop, out_valid, out_ready;
  logic [7:0]  drop_count;
`ifdef ST_ARB_CHANNEL_EN
  logic        out_channel;
`endif

  int total = 0;
  int bad   = 0;

  st_pkt_arbiter #(.DROP_CNT_W(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .data_in0_data          (in0_data),
    .data_in0_empty         (in0_empty),
    .data_in0_startofpacket (in0_sop),
    .data_in0_endofpacket   (in0_eop),
    .data_in0_valid         (in0_valid),
    .data_in0_ready         (in0_ready),
    .data_in1_data          (in1_data),
    .data_in1_empty         (in1_empty),
    .data_in1_startofpacket (in1_sop),
    .data_in1_endofpacket   (in1_eop),
    .data_in1_valid         (in1_valid),
    .data_in1_ready         (in1_ready),
    .data_out_data          (out_data),
    .data_out_empty         (out_empty),
    .data_out_startofpacket (out_sop),
    .data_out_endofpacket   (out_eop),
    .data_out_valid         (out_valid),
    .data_out_ready         (out_ready),
`ifdef ST_ARB_CHANNEL_EN
    .data_out_channel       (out_channel),
`endif
    .drop_count             (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic d0(input logic v, input logic s, input logic e, input logic [31:0] d);
    in0_valid = v; in0_sop = s; in0_eop = e; in0_data = d; in0_empty = 2'd0;
  endtask

  task automatic d1(input logic v, input logic s, input logic e, input logic [31:0] d);
    in1_valid = v; in1_sop = s; in1_eop = e; in1_data = d; in1_empty = 2'd0;
  endtask

  task automatic idle_in();
    d0(1'b0, 1'b0, 1'b0, 32'd0);
    d1(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic chk_chan(input logic exp);
`ifdef ST_ARB_CHANNEL_EN
    chk("channel", 32'(out_channel), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    int k;
    logic exp_ch;
    rst = 1'b1;
    out_ready = 1'b0;
    idle_in();
    cyc(); cyc(); settle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rdy0", 32'(in0_ready), 32'd0);
    chk("rst_rdy1", 32'(in1_ready), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_sop", 32'(out_sop), 32'd0);
    chk("rst_eop", 32'(out_eop), 32'd0);
    cyc(); rst = 1'b0;

    // Single source, 4-beat packet
    cyc(); d0(1, 1, 0, 32'd1); out_ready = 1'b1; settle();
    chk("t1_req_rdy0", 32'(in0_ready), 32'd0);
    chk("t1_req_valid", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(); d0(1, i == 1, i == 4, 32'(i)); in0_empty = (i == 4) ? 2'd2 : 2'd0; settle();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data", out_data, 32'(i));
      chk("t1_sop", 32'(out_sop), 32'(i == 1));
      chk("t1_eop", 32'(out_eop), 32'(i == 4));
      chk("t1_rdy0", 32'(in0_ready), 32'd1);
      chk_chan(1'b0);
    end
    chk("t1_empty", 32'(out_empty), 32'd2);
    cyc(); idle_in(); settle();
    chk("t1_gap_valid", 32'(out_valid), 32'd0);

    // Contention after reset: in0 wins, in1 waits one idle cycle
    cyc(); rst = 1'b1; idle_in();
    cyc(); rst = 1'b0;
    cyc(); d0(1, 1, 0, 32'hA0); d1(1, 1, 0, 32'hB0); settle();
    chk("t2_req_valid", 32'(out_valid), 32'd0);
    chk("t2_req_rdy0", 32'(in0_ready), 32'd0);
    chk("t2_req_rdy1", 32'(in1_ready), 32'd0);
    cyc(); settle();
    chk("t2_a0", out_data, 32'hA0);
    chk("t2_a0_rdy0", 32'(in0_ready), 32'd1);
    chk("t2_a0_rdy1", 32'(in1_ready), 32'd0);
    cyc(); d0(1, 0, 1, 32'hA1); settle();
    chk("t2_a1", out_data, 32'hA1);
    chk("t2_a1_eop", 32'(out_eop), 32'd1);
    chk("t2_a1_rdy1", 32'(in1_ready), 32'd0);
    cyc(); d0(0, 0, 0, 32'd0); settle();
    chk("t2_gap_valid", 32'(out_valid), 32'd0);
    chk("t2_gap_rdy1", 32'(in1_ready), 32'd0);
    cyc(); settle();
    chk("t2_b0", out_data, 32'hB0);
    chk("t2_b0_rdy1", 32'(in1_ready), 32'd1);
    chk("t2_b0_rdy0", 32'(in0_ready), 32'd0);
    chk_chan(1'b1);
    cyc(); d1(1, 0, 1, 32'hB1); settle();
    chk("t2_b1", out_data, 32'hB1);
    cyc(); d0(1, 1, 1, 32'hA2); d1(1, 1, 1, 32'hB2); settle();
    chk("t2_req2_valid", 32'(out_valid), 32'd0);
    cyc(); settle();
    chk("t2_again_in0", out_data, 32'hA2);
    chk("t2_again_rdy1", 32'(in1_ready), 32'd0);
    cyc(); d0(0, 0, 0, 32'd0); settle();
    chk("t2_gap2_valid", 32'(out_valid), 32'd0);
    cyc(); settle();
    chk("t2_b2", out_data, 32'hB2);
    cyc(); idle_in(); settle();
    chk("t2_end_valid", 32'(out_valid), 32'd0);

    // Backpressure: downstream ready alternates during a 5-beat packet
    cyc(); d0(1, 1, 0, 32'h51); out_ready = 1'b1; settle();
    chk("t3_req_valid", 32'(out_valid), 32'd0);
    k = 1;
    for (int c = 0; c < 20 && k <= 5; c++) begin
      cyc(); d0(1, k == 1, k == 5, 32'h50 + 32'(k)); out_ready = (c % 2 == 0); settle();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_data", out_data, 32'h50 + 32'(k));
      chk("t3_rdy0", 32'(in0_ready), 32'(out_ready));
      chk("t3_rdy1", 32'(in1_ready), 32'd0);
      if (out_ready) k++;
    end
    cyc(); idle_in(); out_ready = 1'b1; settle();
    chk("t3_end_valid", 32'(out_valid), 32'd0);

    // Drops of out-of-packet beats in IDLE
    for (int i = 0; i < 3; i++) begin
      cyc(); d1(1, 0, 0, 32'hE0 + 32'(i)); settle();
      chk("t4_rdy1", 32'(in1_ready), 32'd1);
      chk("t4_valid", 32'(out_valid), 32'd0);
    end
    cyc(); d0(1, 0, 0, 32'hE8); d1(1, 0, 0, 32'hE9); settle();
    chk("t4_drop3", 32'(drop_count), 32'd3);
    chk("t4_rdy0", 32'(in0_ready), 32'd1);
    cyc(); idle_in(); settle();
    chk("t4_drop5", 32'(drop_count), 32'd5);
    for (int i = 0; i < 300; i++) begin
      cyc(); d1(1, 0, 0, 32'(i));
    end
    cyc(); idle_in(); settle();
    chk("t4_drop_sat", 32'(drop_count), 32'd255);

    // Reset on beat 2 of an in0 packet
    cyc(); d0(1, 1, 0, 32'h61); settle();
    cyc(); settle();
    chk("t5_b1", out_data, 32'h61);
    cyc(); d0(1, 0, 0, 32'h62); rst = 1'b1; settle();
    chk("t5_rst_rdy0", 32'(in0_ready), 32'd0);
    cyc(); rst = 1'b0; idle_in(); settle();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_rdy0", 32'(in0_ready), 32'd0);
    chk("t5_rdy1", 32'(in1_ready), 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    cyc(); d1(1, 1, 1, 32'hC1); settle();
    chk("t5_req_valid", 32'(out_valid), 32'd0);
    cyc(); settle();
    chk("t5_c1_valid", 32'(out_valid), 32'd1);
    chk("t5_c1", out_data, 32'hC1);
    chk("t5_c1_rdy1", 32'(in1_ready), 32'd1);
    chk_chan(1'b1);

    // Alternating single-beat packets from both sources
    cyc(); d0(1, 1, 1, 32'hD0); d1(1, 1, 1, 32'hD1); settle();
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    chk("t6_idle_rdy0", 32'(in0_ready), 32'd0);
    exp_ch = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cyc(); settle();
      chk("t6_valid", 32'(out_valid), 32'd1);
      chk("t6_data", out_data, exp_ch ? 32'hD1 : 32'hD0);
      chk("t6_rdy0", 32'(in0_ready), 32'(!exp_ch));
      chk("t6_rdy1", 32'(in1_ready), 32'(exp_ch));
      chk_chan(exp_ch);
      cyc(); settle();
      chk("t6_gap", 32'(out_valid), 32'd0);
      exp_ch = ~exp_ch;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
